// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing a bank of 32-bit control registers to the Simulink fabric.
// Each register has a shadow (software view) and an output (fabric view). In
// commit mode, non-pulse registers stage writes in the shadow until software
// commits the whole bank at once.

// One register slot: shadow, fabric-facing output, dirty flag and update strobe.
module opb_reg_slot #(
    parameter bit PULSE  = 1'b0,
    parameter bit COMMIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        commit,
    input  logic [3:0]  be,        // be[3] selects bits [31:24]
    input  logic [31:0] wdata,
    output logic [31:0] shadow,
    output logic [31:0] data_out,
    output logic        dirty,
    output logic        update
);
    logic [31:0] shadow_q, shadow_d, out_q, out_d, merged;
    logic        dirty_q, dirty_d, upd_q, upd_d;

    // Byte-merge the write, then decide whether the output follows now or waits for commit
    always_comb begin
        merged = shadow_q;
        for (int b = 0; b < 4; b++)
            if (be[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        shadow_d = wr_en ? merged : shadow_q;
        out_d    = PULSE ? 32'h0 : out_q;   // pulse outputs fall back to zero after one cycle
        dirty_d  = dirty_q;
        upd_d    = 1'b0;
        if (wr_en) begin
            if (PULSE || !COMMIT) begin
                out_d = merged;
                upd_d = 1'b1;
            end else begin
                dirty_d = 1'b1;
            end
        end else if (commit && !PULSE) begin
            out_d   = shadow_q;
            upd_d   = dirty_q;
            dirty_d = 1'b0;
        end
    end

    // Slot state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            out_q    <= '0;
            dirty_q  <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            dirty_q  <= dirty_d;
            upd_q    <= upd_d;
        end
    end

    assign shadow   = shadow_q;
    assign data_out = out_q;
    assign dirty    = dirty_q;
    assign update   = upd_q;
endmodule

module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000C00,
    parameter logic [31:0] C_HIGHADDR    = 32'h01000CFF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter logic [31:0] C_PULSE_MASK  = 32'h0,
    parameter int          C_COMMIT_MODE = 0,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                           OPB_Clk,
    input  logic                           OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
    input  logic [0:3]                     OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
    input  logic                           OPB_RNW,
    input  logic                           OPB_select,
    input  logic                           OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
    output logic                           Sl_xferAck,
    output logic                           Sl_errAck,
    output logic                           Sl_retry,
    output logic                           Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]       user_data_out,
    output logic [C_NUM_REGS-1:0]          user_update
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam int         IW     = C_OPB_AWIDTH - 2;
    localparam logic [IW-1:0] NREG_IDX = IW'(C_NUM_REGS);
    localparam bit         FAMILY_SET = (C_FAMILY != "");

    logic [31:0] addr, off, wdata, rd_word;
    logic [3:0]  be_user;
    logic [IW-1:0] idx;
    logic        hit, is_status, commit;
    logic [C_NUM_REGS-1:0] reg_hit, wr_en, dirty, update;
    logic [C_NUM_REGS-1:0][31:0] shadow, outs;

    logic [1:0]  state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dbus_q, dbus_d;
    logic        unused_ok;

    // OPB bit 0 is the MSB, so a straight assignment yields the numeric value
    assign addr    = OPB_ABus;
    assign wdata   = OPB_DBus;
    assign be_user = {OPB_BE[0], OPB_BE[1], OPB_BE[2], OPB_BE[3]};
    assign off     = addr - C_BASEADDR;
    assign idx     = off[C_OPB_AWIDTH-1:2];
    assign hit     = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign is_status = (idx == NREG_IDX);

    // Decode the register index and build the read word from shadows or the dirty mask
    always_comb begin
        reg_hit = '0;
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == IW'(i)) begin
                reg_hit[i] = 1'b1;
                rd_word    = shadow[i];
            end
        end
        if (is_status) rd_word[C_NUM_REGS-1:0] = dirty;
    end

    // Ack FSM: one ack per select, writes and commits take effect on the IDLE->ACK edge
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dbus_d  = '0;
        wr_en   = '0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (OPB_select && hit) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (OPB_RNW) begin
                        dbus_d = rd_word;
                    end else begin
                        wr_en  = reg_hit;
                        commit = (C_COMMIT_MODE != 0) && is_status && be_user[0] && wdata[0];
                    end
                end
            end
            S_ACK:   state_d = S_HOLD;
            S_HOLD:  if (!OPB_select) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and bus-side output registers
    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dbus_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dbus_q  <= dbus_d;
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        opb_reg_slot #(
            .PULSE  (C_PULSE_MASK[i]),
            .COMMIT (C_COMMIT_MODE != 0)
        ) u_slot (
            .clk      (OPB_Clk),
            .rst_n    (OPB_Rst_n),
            .wr_en    (wr_en[i]),
            .commit   (commit),
            .be       (be_user),
            .wdata    (wdata),
            .shadow   (shadow[i]),
            .data_out (outs[i]),
            .dirty    (dirty[i]),
            .update   (update[i])
        );
    end

    assign Sl_DBus       = dbus_q;
    assign Sl_xferAck    = ack_q;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = outs;
    assign user_update   = update;
    assign unused_ok     = ^{OPB_seqAddr, off[1:0], FAMILY_SET};
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: one immediate-commit instance (a)
// and one commit-mode instance (b), both with register 5 in pulse mode.
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE = 32'h01000C00;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:31]  abus = '0, dbus = '0;
    logic [0:3]   be = '0;
    logic         rnw = 1'b0, sel_a = 1'b0, sel_b = 1'b0, seq = 1'b0;
    logic [0:31]  dbus_a, dbus_b;
    logic         ack_a, ack_b, err_a, err_b, rty_a, rty_b, tos_a, tos_b;
    logic [255:0] uo_a, uo_b;
    logic [7:0]   upd_a, upd_b;

    int checks = 0, errors = 0;
    int acks_a = 0, acks_b = 0, exp_acks_a = 0, exp_acks_b = 0;
    logic [31:0] q_a[$], q_b[$];
    logic [31:0] exp_a, exp_b;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(.C_PULSE_MASK(32'h20), .C_COMMIT_MODE(0)) dut_a (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_a), .OPB_seqAddr(seq), .Sl_DBus(dbus_a),
        .Sl_xferAck(ack_a), .Sl_errAck(err_a), .Sl_retry(rty_a), .Sl_toutSup(tos_a),
        .user_data_out(uo_a), .user_update(upd_a));

    opb_register_bank_ppc2simulink #(.C_PULSE_MASK(32'h20), .C_COMMIT_MODE(1)) dut_b (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel_b), .OPB_seqAddr(seq), .Sl_DBus(dbus_b),
        .Sl_xferAck(ack_b), .Sl_errAck(err_b), .Sl_retry(rty_b), .Sl_toutSup(tos_b),
        .user_data_out(uo_b), .user_update(upd_b));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the next expected read word; idle cycles must show zero data
    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            acks_a++;
            chk("a_ack_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                chk("a_rdata", dbus_a, exp_a);
            end
        end else if (rst_n) begin
            chk("a_dbus_idle", dbus_a, 0);
        end
    end

    always @(negedge clk) begin
        if (ack_b === 1'b1) begin
            acks_b++;
            chk("b_ack_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                exp_b = q_b.pop_front();
                chk("b_rdata", dbus_b, exp_b);
            end
        end else if (rst_n) begin
            chk("b_dbus_idle", dbus_b, 0);
        end
    end

    // One transfer; returns on the negedge of the ack cycle, after holding select `hold` more cycles
    task automatic xfer(input bit b, input logic [31:0] off, input bit rd, input logic [3:0] bev,
                        input logic [31:0] d, input logic [31:0] exp, input int hold);
        bit got = 1'b0;
        repeat (2) @(negedge clk);
        if (b) begin q_b.push_back(rd ? exp : 32'h0); exp_acks_b++; end
        else   begin q_a.push_back(rd ? exp : 32'h0); exp_acks_a++; end
        abus = BASE + off; rnw = rd; be = bev; dbus = d;
        if (b) sel_b = 1'b1; else sel_a = 1'b1;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clk);
            got = b ? ack_b : ack_a;
        end
        chk("xfer_ack_seen", got, 1);
        if (!got) begin
            if (b) void'(q_b.pop_back()); else void'(q_a.pop_back());
        end
        repeat (hold) @(negedge clk);
        sel_a = 1'b0; sel_b = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_uo_a", uo_a, 0);
        chk("rst_uo_b", uo_b, 0);
        chk("rst_upd", {upd_a, upd_b}, 0);
        chk("rst_ack", {ack_a, ack_b, err_a, rty_a, tos_a, err_b, rty_b, tos_b}, 0);
        rst_n = 1'b1;

        // full-word write, immediate mode
        xfer(0, 32'h08, 0, 4'b1111, 32'hDEADBEEF, 0, 0);
        chk("wr_full_out", uo_a[95:64], 32'hDEADBEEF);
        chk("wr_full_upd", upd_a, 8'h04);
        @(negedge clk);
        chk("wr_full_upd_clr", upd_a, 8'h00);
        xfer(0, 32'h08, 1, 4'b1111, 0, 32'hDEADBEEF, 0);

        // byte-enable write: BE[1] and BE[3]
        xfer(0, 32'h08, 0, 4'b0101, 32'h11223344, 0, 0);
        chk("wr_be_out", uo_a[95:64], 32'hDE22BE44);
        xfer(0, 32'h08, 1, 4'b1111, 0, 32'hDE22BE44, 0);
        xfer(0, 32'h0B, 1, 4'b1111, 0, 32'hDE22BE44, 0);   // low address bits ignored

        // pulse register 5
        xfer(0, 32'h14, 0, 4'b1111, 32'h1, 0, 0);
        chk("pulse_hi", uo_a[191:160], 32'h1);
        chk("pulse_upd", upd_a, 8'h20);
        @(negedge clk);
        chk("pulse_lo", uo_a[191:160], 32'h0);
        xfer(0, 32'h14, 1, 4'b1111, 0, 32'h1, 0);

        // commit mode staging and commit
        xfer(1, 32'h00, 0, 4'b1111, 32'hA5A5A5A5, 0, 0);
        chk("stage0_out", uo_b, 0);
        chk("stage0_upd", upd_b, 0);
        xfer(1, 32'h0C, 0, 4'b1111, 32'h12345678, 0, 0);
        chk("stage3_out", uo_b, 0);
        xfer(1, 32'h20, 1, 4'b1111, 0, 32'h9, 0);
        xfer(1, 32'h0C, 1, 4'b1111, 0, 32'h12345678, 0);
        xfer(1, 32'h20, 0, 4'b1111, 32'h1, 0, 0);
        chk("commit_r0", uo_b[31:0], 32'hA5A5A5A5);
        chk("commit_r3", uo_b[127:96], 32'h12345678);
        chk("commit_upd", upd_b, 8'h09);
        xfer(1, 32'h20, 1, 4'b1111, 0, 32'h0, 0);
        // pulse register bypasses staging even in commit mode
        xfer(1, 32'h14, 0, 4'b1111, 32'h80000000, 0, 0);
        chk("b_pulse_hi", uo_b[191:160], 32'h80000000);
        xfer(1, 32'h20, 1, 4'b1111, 0, 32'h0, 0);
        // commit word is write-ignored in immediate mode
        xfer(0, 32'h20, 0, 4'b1111, 32'h1, 0, 0);
        chk("a_commit_ignored", upd_a, 8'h00);

        // held select yields a single ack
        xfer(0, 32'h04, 1, 4'b1111, 0, 32'h0, 9);
        repeat (4) @(negedge clk);
        chk("held_one_ack", acks_a, exp_acks_a);

        // unused in-range index: write ignored, read zero
        xfer(0, 32'h24, 0, 4'b1111, 32'hFFFFFFFF, 0, 0);
        xfer(0, 32'h24, 1, 4'b1111, 0, 32'h0, 0);

        // out-of-range address is never acknowledged
        repeat (2) @(negedge clk);
        abus = BASE + 32'h100; rnw = 1'b1; sel_a = 1'b1;
        repeat (6) @(negedge clk);
        sel_a = 1'b0;
        chk("miss_no_ack", acks_a, exp_acks_a);

        // reset during the ack cycle
        xfer(0, 32'h04, 0, 4'b1111, 32'hCAFE0000, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack", ack_a, 0);
        chk("rst_mid_uo", uo_a, 0);
        chk("rst_mid_upd", upd_a, 0);
        chk("rst_mid_dbus", dbus_a, 0);
        rst_n = 1'b1;
        xfer(0, 32'h00, 0, 4'b1111, 32'h55AA55AA, 0, 0);
        chk("post_rst_out", uo_a[31:0], 32'h55AA55AA);
        xfer(0, 32'h00, 1, 4'b1111, 0, 32'h55AA55AA, 0);
        xfer(0, 32'h08, 1, 4'b1111, 0, 32'h0, 0);
        xfer(0, 32'h04, 1, 4'b1111, 0, 32'h0, 0);

        repeat (4) @(negedge clk);
        chk("final_acks_a", acks_a, exp_acks_a);
        chk("final_acks_b", acks_b, exp_acks_b);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
